// File: rtl/crosshair_hsv_sampler.sv
// Crosshair HSV sampler: averages h/s/v over a square window around the
// crosshair once per frame and presents the means to the threshold stage.
module crosshair_hsv_sampler #(
    parameter int WIN_LOG2 = 2,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           frame_start,
    input  logic           pixel_valid,
    input  logic [X_W-1:0] hcount,
    input  logic [Y_W-1:0] vcount,
    input  logic [7:0]     h,
    input  logic [7:0]     s,
    input  logic [7:0]     v,
    input  logic [X_W-1:0] cross_x,
    input  logic [Y_W-1:0] cross_y,
    input  logic           freeze,
    output logic [7:0]     h_sel,
    output logic [7:0]     s_sel,
    output logic [7:0]     v_sel,
    output logic           sel_valid,
    output logic           sample_err
);
    localparam int SH = 2 * WIN_LOG2;
    localparam int SW = 8 + SH;
    localparam int CW = SH + 1;
    localparam int HALF = 2 ** (WIN_LOG2 - 1);
    localparam logic [CW-1:0] FULL = {1'b1, {(CW-1){1'b0}}};
    localparam logic signed [X_W:0] XH  = (X_W+1)'(HALF);
    localparam logic signed [X_W:0] XHM = (X_W+1)'(HALF - 1);
    localparam logic signed [Y_W:0] YH  = (Y_W+1)'(HALF);
    localparam logic signed [Y_W:0] YHM = (Y_W+1)'(HALF - 1);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        ACCUM,
        UPDATE
    } state_t;

    state_t         state_q, state_d;
    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;
    logic [SW-1:0]  hacc_q, hacc_d, sacc_q, sacc_d, vacc_q, vacc_d;
    logic [CW-1:0]  cnt_q, cnt_d, csnap_q, csnap_d;
    logic [7:0]     hsnap_q, hsnap_d, ssnap_q, ssnap_d, vsnap_q, vsnap_d;
    logic           pupd_q, pupd_d, perr_q, perr_d;
    logic [7:0]     pm_h_q, pm_h_d, pm_s_q, pm_s_d, pm_v_q, pm_v_d;
    logic [7:0]     hsel_q, hsel_d, ssel_q, ssel_d, vsel_q, vsel_d;
    logic           vld_q, vld_d, err_q, err_d;

    logic signed [X_W:0] x_c, x_lo, x_hi, x_p;
    logic signed [Y_W:0] y_c, y_lo, y_hi, y_p;
    logic                in_win, accept;
    logic [SW-1:0]       hb, sb, vb;
    logic [CW-1:0]       cb;

    // A pixel coincident with frame_start is judged against the new crosshair.
    assign x_c  = $signed({1'b0, frame_start ? cross_x : cx_q});
    assign y_c  = $signed({1'b0, frame_start ? cross_y : cy_q});
    assign x_lo = x_c - XH;
    assign x_hi = x_c + XHM;
    assign y_lo = y_c - YH;
    assign y_hi = y_c + YHM;
    assign x_p  = $signed({1'b0, hcount});
    assign y_p  = $signed({1'b0, vcount});

    assign in_win = pixel_valid
                 && (x_p >= x_lo) && (x_p <= x_hi)
                 && (y_p >= y_lo) && (y_p <= y_hi);
    assign accept = in_win
                 && (frame_start
                     || ((state_q != WAIT_FRAME) && (cnt_q != FULL)));

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        hsnap_d = hsnap_q;
        ssnap_d = ssnap_q;
        vsnap_d = vsnap_q;
        csnap_d = csnap_q;

        hb = frame_start ? '0 : hacc_q;
        sb = frame_start ? '0 : sacc_q;
        vb = frame_start ? '0 : vacc_q;
        cb = frame_start ? '0 : cnt_q;

        hacc_d = accept ? hb + {{(SW-8){1'b0}}, h} : hb;
        sacc_d = accept ? sb + {{(SW-8){1'b0}}, s} : sb;
        vacc_d = accept ? vb + {{(SW-8){1'b0}}, v} : vb;
        cnt_d  = accept ? cb + CW'(1) : cb;

        unique case (state_q)
            WAIT_FRAME: begin
                if (frame_start) begin
                    state_d = ACCUM;
                    cx_d    = cross_x;
                    cy_d    = cross_y;
                end
            end
            ACCUM, UPDATE: begin
                state_d = ACCUM;
                if (frame_start) begin
                    state_d = UPDATE;
                    cx_d    = cross_x;
                    cy_d    = cross_y;
                    hsnap_d = hacc_q[SW-1:SH];
                    ssnap_d = sacc_q[SW-1:SH];
                    vsnap_d = vacc_q[SW-1:SH];
                    csnap_d = cnt_q;
                end
            end
            default: state_d = WAIT_FRAME;
        endcase

        // Decision is taken in UPDATE and published one edge later.
        pupd_d = (state_q == UPDATE) && (csnap_q == FULL) && !freeze;
        perr_d = (state_q == UPDATE) && (csnap_q != FULL);
        pm_h_d = hsnap_q;
        pm_s_d = ssnap_q;
        pm_v_d = vsnap_q;

        vld_d  = pupd_q;
        hsel_d = pupd_q ? pm_h_q : hsel_q;
        ssel_d = pupd_q ? pm_s_q : ssel_q;
        vsel_d = pupd_q ? pm_v_q : vsel_q;
        err_d  = pupd_q ? 1'b0 : (perr_q | err_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= WAIT_FRAME;
            cx_q    <= '0;
            cy_q    <= '0;
            hacc_q  <= '0;
            sacc_q  <= '0;
            vacc_q  <= '0;
            cnt_q   <= '0;
            hsnap_q <= '0;
            ssnap_q <= '0;
            vsnap_q <= '0;
            csnap_q <= '0;
            pupd_q  <= 1'b0;
            perr_q  <= 1'b0;
            pm_h_q  <= '0;
            pm_s_q  <= '0;
            pm_v_q  <= '0;
            hsel_q  <= '0;
            ssel_q  <= '0;
            vsel_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            hacc_q  <= hacc_d;
            sacc_q  <= sacc_d;
            vacc_q  <= vacc_d;
            cnt_q   <= cnt_d;
            hsnap_q <= hsnap_d;
            ssnap_q <= ssnap_d;
            vsnap_q <= vsnap_d;
            csnap_q <= csnap_d;
            pupd_q  <= pupd_d;
            perr_q  <= perr_d;
            pm_h_q  <= pm_h_d;
            pm_s_q  <= pm_s_d;
            pm_v_q  <= pm_v_d;
            hsel_q  <= hsel_d;
            ssel_q  <= ssel_d;
            vsel_q  <= vsel_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign h_sel      = hsel_q;
    assign s_sel      = ssel_q;
    assign v_sel      = vsel_q;
    assign sel_valid  = vld_q;
    assign sample_err = err_q;

endmodule

// File: tb/tb_crosshair_hsv_sampler.sv
// Bench for crosshair_hsv_sampler: directed steps then random frames,
// compared every cycle against a frame-level averaging model.
module tb_crosshair_hsv_sampler;
    localparam int L    = 2;
    localparam int X_W  = 11;
    localparam int Y_W  = 10;
    localparam int N    = 1 << (2 * L);
    localparam int HALF = 1 << (L - 1);

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           frame_start = 1'b0;
    logic           pixel_valid = 1'b0;
    logic [X_W-1:0] hcount = '0;
    logic [Y_W-1:0] vcount = '0;
    logic [7:0]     h = '0, s = '0, v = '0;
    logic [X_W-1:0] cross_x = '0;
    logic [Y_W-1:0] cross_y = '0;
    logic           freeze = 1'b0;
    logic [7:0]     h_sel, s_sel, v_sel;
    logic           sel_valid, sample_err;

    always #5 clk = ~clk;

    crosshair_hsv_sampler #(.WIN_LOG2(L), .X_W(X_W), .Y_W(Y_W)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .pixel_valid(pixel_valid), .hcount(hcount), .vcount(vcount),
        .h(h), .s(s), .v(v), .cross_x(cross_x), .cross_y(cross_y),
        .freeze(freeze), .h_sel(h_sel), .s_sel(s_sel), .v_sel(v_sel),
        .sel_valid(sel_valid), .sample_err(sample_err)
    );

    // kind: 0 publish means, 1 frozen (hold), 2 incomplete window
    typedef struct {
        int due;
        int kind;
        int mh;
        int ms;
        int mv;
    } ev_t;

    ev_t q[$];
    int  errors = 0, checks = 0, k = 0;
    bit  act = 0, frz = 0;
    int  m_cx = 0, m_cy = 0, sh = 0, ss = 0, sv = 0, cnt = 0;
    int  eh = 0, es = 0, ev = 0, evalid = 0, eerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit inwin(input int x, input int y);
        return x >= m_cx - HALF && x <= m_cx + HALF - 1
            && y >= m_cy - HALF && y <= m_cy + HALF - 1;
    endfunction

    task automatic cyc(input bit fs, input bit pv, input int x, input int y,
                       input int hh, input int s_, input int v_);
        frame_start = fs;
        pixel_valid = pv;
        hcount = X_W'(x);
        vcount = Y_W'(y);
        h = 8'(hh);
        s = 8'(s_);
        v = 8'(v_);
        freeze = frz;
        @(posedge clk);
        k++;
        if (!reset_n) begin
            act = 0;
            q.delete();
            sh = 0; ss = 0; sv = 0; cnt = 0;
            eh = 0; es = 0; ev = 0; evalid = 0; eerr = 0;
        end else begin
            evalid = 0;
            while (q.size() > 0 && q[0].due == k) begin
                ev_t e;
                e = q.pop_front();
                if (e.kind == 0) begin
                    eh = e.mh; es = e.ms; ev = e.mv;
                    evalid = 1; eerr = 0;
                end else if (e.kind == 2) begin
                    eerr = 1;
                end
            end
            if (fs) begin
                if (act) begin
                    ev_t e;
                    e.due  = k + 2;
                    e.kind = (cnt < N) ? 2 : (frz ? 1 : 0);
                    e.mh = sh / N; e.ms = ss / N; e.mv = sv / N;
                    q.push_back(e);
                end
                act = 1;
                m_cx = int'(cross_x);
                m_cy = int'(cross_y);
                sh = 0; ss = 0; sv = 0; cnt = 0;
            end
            if (act && pv && inwin(x, y) && cnt < N) begin
                sh += hh; ss += s_; sv += v_;
                cnt++;
            end
        end
        #1;
        chk("sel_valid", sel_valid, evalid);
        chk("h_sel", h_sel, eh);
        chk("s_sel", s_sel, es);
        chk("v_sel", v_sel, ev);
        chk("sample_err", sample_err, eerr);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input int x, input int y,
                       input int hh, input int s_, input int v_);
        cyc(0, 1, x, y, hh, s_, v_);
    endtask

    task automatic sframe(input int cx, input int cy);
        cross_x = X_W'(cx);
        cross_y = Y_W'(cy);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
    endtask

    task automatic win(input int cx, input int cy,
                       input int hh, input int s_, input int v_);
        for (int y = cy - 2; y <= cy + 1; y++)
            for (int x = cx - 2; x <= cx + 1; x++)
                pix(x, y, hh, s_, v_);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        idle();
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_h", h_sel, 0);
        chk("rst_valid", sel_valid, 0);
        chk("rst_err", sample_err, 0);

        sframe(100, 80);
        chk("first_fs_valid", sel_valid, 0);
        for (int y = 76; y <= 83; y++)
            for (int x = 96; x <= 103; x++)
                pix(x, y, 40, 200, 150);
        sframe(100, 80);
        chk("tp1_valid", sel_valid, 1);
        chk("tp1_h", h_sel, 40);
        chk("tp1_s", s_sel, 200);
        chk("tp1_v", v_sel, 150);
        chk("tp1_err", sample_err, 0);
        idle();
        chk("tp1_pulse_end", sel_valid, 0);

        for (int y = 78; y <= 81; y++)
            for (int x = 98; x <= 101; x++)
                pix(x, y, x - 98, 10, 10);
        sframe(1, 80);
        chk("tp2_h_trunc", h_sel, 1);
        chk("tp2_s", s_sel, 10);

        for (int y = 78; y <= 81; y++)
            for (int x = 0; x <= 5; x++)
                pix(x, y, 77, 77, 77);
        sframe(100, 80);
        chk("tp3_valid", sel_valid, 0);
        chk("tp3_err", sample_err, 1);
        chk("tp3_hold_h", h_sel, 1);
        win(100, 80, 40, 50, 60);
        sframe(100, 80);
        chk("tp3_err_clear", sample_err, 0);
        chk("tp3_h", h_sel, 40);

        frz = 1;
        win(100, 80, 90, 90, 90);
        sframe(100, 80);
        chk("tp4_frozen_h", h_sel, 40);
        chk("tp4_frozen_valid", sel_valid, 0);
        frz = 0;
        win(100, 80, 90, 90, 90);
        sframe(100, 80);
        chk("tp4_h", h_sel, 90);

        pix(99, 79, 5, 5, 5);
        pix(100, 79, 5, 5, 5);
        do_reset();
        chk("tp5_h", h_sel, 0);
        chk("tp5_err", sample_err, 0);
        sframe(100, 80);
        chk("tp5_first_valid", sel_valid, 0);
        win(100, 80, 50, 60, 70);
        sframe(100, 80);
        chk("tp5_h", h_sel, 50);
        chk("tp5_v", v_sel, 70);

        win(100, 80, 7, 7, 7);
        cross_x = X_W'(100);
        cross_y = Y_W'(80);
        cyc(1, 1, 98, 78, 255, 0, 0);
        idle();
        idle();
        chk("tp6_prev_h", h_sel, 7);
        for (int y = 78; y <= 81; y++)
            for (int x = 98; x <= 101; x++)
                if (!(x == 98 && y == 78)) pix(x, y, 0, 0, 0);
        sframe(100, 80);
        chk("tp6_h", h_sel, 15);

        for (int f = 0; f < 40; f++) begin
            int cx, cy;
            cx = $urandom_range(0, 20);
            cy = $urandom_range(0, 20);
            if ($urandom_range(0, 7) == 0) begin
                cross_x = X_W'(cx);
                cyc(1, 0, 0, 0, 0, 0, 0);
            end
            sframe(cx, cy);
            frz = ($urandom_range(0, 3) == 0);
            for (int y = cy - 3; y <= cy + 2; y++)
                for (int x = cx - 3; x <= cx + 2; x++) begin
                    if (x < 0 || y < 0) continue;
                    if ($urandom_range(0, 9) == 0) continue;
                    pix(x, y, $urandom_range(0, 255),
                        $urandom_range(0, 255), $urandom_range(0, 255));
                    if ($urandom_range(0, 9) == 0)
                        pix(x, y, $urandom_range(0, 255),
                            $urandom_range(0, 255), $urandom_range(0, 255));
                    if ($urandom_range(0, 7) == 0) idle();
                end
        end
        sframe(10, 10);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
